// File: rtl/audio_resamp_pkg.sv
// Shared types and helpers for the audio resampling path: sample/phase
// types, the resampler FSM encoding and the phase-increment calculation.
package audio_resamp_pkg;

    localparam int unsigned IW_DEF     = 16;
    localparam int unsigned FRAC_W_DEF = 12;

    typedef logic signed [IW_DEF-1:0] sample_t;
    typedef logic [FRAC_W_DEF-1:0]    phase_t;

    typedef enum logic [1:0] {
        PRIME0 = 2'd0,
        PRIME1 = 2'd1,
        RUN    = 2'd2
    } rs_state_t;

    // floor(2^frac_w * rate_in / mclk), never below 1 so the phase always
    // advances between input samples.
    function automatic int unsigned calc_phase_inc(
        input longint unsigned mclk,
        input longint unsigned rate_in,
        input int unsigned     frac_w
    );
        longint unsigned q;
        q = ((64'd1 << frac_w) * rate_in) / mclk;
        if (q < 64'd1) begin
            q = 64'd1;
        end else begin
            q = q;
        end
        return q[31:0];
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Bresenham rate divider: emits a one-cycle tick at an exact mean rate of
// RATE ticks per MCLK_RATE clocks. Also usable for the FIR input strobe.
module rate_tick_gen #(
    parameter int unsigned MCLK_RATE = 53693175,
    parameter int unsigned RATE      = 48000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_o
);

    localparam logic [32:0] RATE_W = 33'(RATE);
    localparam logic [32:0] MCLK_W = 33'(MCLK_RATE);

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic        tick_q;
    logic        tick_d;
    logic [32:0] sum_s;

    // Next accumulator value and tick: wrap by MCLK_RATE when the sum reaches it.
    always_comb begin
        sum_s = {1'b0, acc_q} + RATE_W;
        if (sum_s >= MCLK_W) begin
            acc_d  = 32'(sum_s - MCLK_W);
            tick_d = 1'b1;
        end else begin
            acc_d  = sum_s[31:0];
            tick_d = 1'b0;
        end
    end

    // Accumulator and registered tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q  <= 32'd0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/fir_linear_resampler.sv
// Linear-interpolating rate converter placed after the PSG FIR pre-filter.
// Keeps the last two input samples and a phase that ramps from 0 at each new
// sample; on every output tick it interpolates between them in a 3-stage
// pipeline (capture, multiply, round/add).
module fir_linear_resampler
    import audio_resamp_pkg::*;
#(
    parameter int unsigned IW           = 16,
    parameter int unsigned FRAC_W       = 12,
    parameter int unsigned MCLK_RATE    = 53693175,
    parameter int unsigned DATA_CLK_IN  = 300000,
    parameter int unsigned DATA_CLK_OUT = 48000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] data_in,
    output logic signed [IW-1:0] data_out,
    output logic                 out_valid,
    output logic                 underrun
);

    localparam int unsigned PHASE_INC = calc_phase_inc(64'(MCLK_RATE), 64'(DATA_CLK_IN), FRAC_W);
    localparam int unsigned PW        = IW + FRAC_W + 2;

    localparam logic [FRAC_W:0]         PHASE_INC_W = (FRAC_W+1)'(PHASE_INC);
    localparam logic [FRAC_W:0]         PHASE_MAX_W = {1'b0, {FRAC_W{1'b1}}};
    localparam logic signed [PW-1:0]    ROUND_C     = {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // Output-rate tick.
    logic tick_s;

    rate_tick_gen #(
        .MCLK_RATE (MCLK_RATE),
        .RATE      (DATA_CLK_OUT)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_o  (tick_s)
    );

    // Input history, phase, sticky underrun, FSM.
    rs_state_t             state_q, state_d;
    logic signed [IW-1:0]  s_prev_q, s_prev_d;
    logic signed [IW-1:0]  s_curr_q, s_curr_d;
    logic [FRAC_W-1:0]     phase_q, phase_d;
    logic [FRAC_W:0]       phase_sum_s;
    logic                  underrun_q, underrun_d;

    // Interpolation pipeline.
    logic                  s1_fire_s;
    logic                  v1_q, v1_d;
    logic signed [IW-1:0]  base1_q, base1_d;
    logic signed [IW:0]    diff1_q, diff1_d;
    logic signed [FRAC_W:0] frac1_q, frac1_d;
    logic                  v2_q, v2_d;
    logic signed [IW-1:0]  base2_q, base2_d;
    logic signed [PW-1:0]  prod2_q, prod2_d;
    logic signed [PW-1:0]  rnd_s;
    logic signed [PW-1:0]  shift_s;
    logic signed [PW-1:0]  base_ext_s;
    logic signed [IW-1:0]  data_out_q, data_out_d;
    logic                  out_valid_q, out_valid_d;

    // FSM next state: two samples are needed before interpolation is meaningful.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIME0: begin
                if (in_valid) begin
                    state_d = PRIME1;
                end else begin
                    state_d = PRIME0;
                end
            end
            PRIME1: begin
                if (in_valid) begin
                    state_d = RUN;
                end else begin
                    state_d = PRIME1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = PRIME0;
            end
        endcase
    end

    // Sample history shift and saturating phase ramp; a pinned phase in RUN
    // means the input stream stalled.
    always_comb begin
        s_prev_d    = s_prev_q;
        s_curr_d    = s_curr_q;
        phase_d     = phase_q;
        underrun_d  = underrun_q;
        phase_sum_s = {1'b0, phase_q} + PHASE_INC_W;
        if (in_valid) begin
            s_prev_d = s_curr_q;
            s_curr_d = data_in;
            phase_d  = {FRAC_W{1'b0}};
        end else if (phase_sum_s > PHASE_MAX_W) begin
            phase_d = {FRAC_W{1'b1}};
            if (state_q == RUN) begin
                underrun_d = 1'b1;
            end else begin
                underrun_d = underrun_q;
            end
        end else begin
            phase_d = phase_sum_s[FRAC_W-1:0];
        end
    end

    // Stage 1 captures the pre-update history so a colliding input sample
    // does not leak into the current output.
    always_comb begin
        s1_fire_s = tick_s && (state_q == RUN);
        v1_d      = s1_fire_s;
        base1_d   = base1_q;
        diff1_d   = diff1_q;
        frac1_d   = frac1_q;
        if (s1_fire_s) begin
            base1_d = s_prev_q;
            diff1_d = {s_curr_q[IW-1], s_curr_q} - {s_prev_q[IW-1], s_prev_q};
            frac1_d = {1'b0, phase_q};
        end else begin
            base1_d = base1_q;
        end
    end

    // Stage 2: signed slope times phase fraction.
    always_comb begin
        v2_d    = v1_q;
        base2_d = base2_q;
        prod2_d = prod2_q;
        if (v1_q) begin
            base2_d = base1_q;
            prod2_d = diff1_q * frac1_q;
        end else begin
            prod2_d = prod2_q;
        end
    end

    // Stage 3: round-half-up, arithmetic shift, add base. The result stays
    // between the two samples, so truncation to IW cannot overflow.
    always_comb begin
        rnd_s       = prod2_q + ROUND_C;
        shift_s     = rnd_s >>> FRAC_W;
        base_ext_s  = PW'(base2_q);
        out_valid_d = v2_q;
        data_out_d  = data_out_q;
        if (v2_q) begin
            data_out_d = IW'(base_ext_s + shift_s);
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Control and history registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= PRIME0;
            s_prev_q   <= {IW{1'b0}};
            s_curr_q   <= {IW{1'b0}};
            phase_q    <= {FRAC_W{1'b0}};
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_prev_q   <= s_prev_d;
            s_curr_q   <= s_curr_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1_q        <= 1'b0;
            base1_q     <= {IW{1'b0}};
            diff1_q     <= {(IW+1){1'b0}};
            frac1_q     <= {(FRAC_W+1){1'b0}};
            v2_q        <= 1'b0;
            base2_q     <= {IW{1'b0}};
            prod2_q     <= {PW{1'b0}};
            data_out_q  <= {IW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            base1_q     <= base1_d;
            diff1_q     <= diff1_d;
            frac1_q     <= frac1_d;
            v2_q        <= v2_d;
            base2_q     <= base2_d;
            prod2_q     <= prod2_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_fir_linear_resampler.sv
// Directed bench for fir_linear_resampler with a scoreboard fed by a
// behavioural model of tick timing, history and interpolation.
module tb_fir_linear_resampler;

    localparam int MCLK = 100;
    localparam int RIN  = 10;
    localparam int ROUT = 4;
    localparam int PINC = 409;
    localparam int PMAX = 4095;

    logic               clk      = 1'b0;
    logic               reset_n  = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] data_in  = 16'sd0;
    logic signed [15:0] data_out;
    logic               out_valid;
    logic               underrun;

    fir_linear_resampler #(
        .IW           (16),
        .FRAC_W       (12),
        .MCLK_RATE    (MCLK),
        .DATA_CLK_IN  (RIN),
        .DATA_CLK_OUT (ROUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        logic signed [15:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // model state mirrors what the DUT holds during the current cycle
    int m_acc   = 0;
    int m_phase = 0;
    int m_state = 0;
    int m_prev  = 0;
    int m_curr  = 0;
    int m_diff  = 0;
    int m_p     = 0;
    int m_e     = 0;
    bit m_tick  = 1'b0;

    // behavioural model: predicts each output and the cycle it appears in
    always @(posedge clk) begin
        if (!reset_n) begin
            m_acc = 0; m_tick = 1'b0; m_prev = 0; m_curr = 0;
            m_phase = 0; m_state = 0;
            sb.delete();
        end else begin
            if (m_tick && m_state == 2) begin
                m_diff = m_curr - m_prev;
                m_p    = m_diff * m_phase + 2048;
                m_e    = m_prev + (m_p >>> 12);
                sb.push_back('{due: cyc + 3, val: 16'(m_e)});
            end
            if (m_acc + ROUT >= MCLK) begin
                m_acc  = m_acc + ROUT - MCLK;
                m_tick = 1'b1;
            end else begin
                m_acc  = m_acc + ROUT;
                m_tick = 1'b0;
            end
            if (in_valid) begin
                m_prev  = m_curr;
                m_curr  = int'(data_in);
                m_phase = 0;
                if (m_state < 2) m_state = m_state + 1;
            end else if (m_phase + PINC > PMAX) begin
                m_phase = PMAX;
            end else begin
                m_phase = m_phase + PINC;
            end
        end
        cyc = cyc + 1;
    end

    // scoreboard: every strobe must match the next predicted output
    always @(negedge clk) begin
        automatic bit exp_due = (sb.size() > 0) && (sb[0].due == cyc);
        if (out_valid !== 1'b0 || exp_due) begin
            vectors++;
            assert (out_valid === exp_due) else begin
                miscompares++;
                $error("FAIL sb_valid: observed %b expected %b at cycle %0d", out_valid, exp_due, cyc);
            end
            if (exp_due) begin
                if (out_valid === 1'b1) begin
                    vectors++;
                    assert (data_out === sb[0].val) else begin
                        miscompares++;
                        $error("FAIL sb_data: observed %0d expected %0d at cycle %0d", data_out, sb[0].val, cyc);
                    end
                end
                popped = sb.pop_front();
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic signed [15:0] v);
        in_valid = 1'b1;
        data_in  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        data_in  = 16'sd0;
        step(3);
        reset_n  = 1'b1;
    endtask

    // advance until the next output tick is exactly n cycles away
    task automatic wait_tick_in(input int n);
        int guard = 0;
        while (((MCLK - m_acc) / ROUT) != n && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            vectors++;
            miscompares++;
            $error("FAIL align: tick distance %0d never reached %0d", (MCLK - m_acc) / ROUT, n);
        end
    endtask

    initial begin
        int last;
        int nticks;
        int nov;
        bit seen;

        // reset state and tick spacing with no input
        @(negedge clk);
        do_reset();
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_phase", 32'(dut.phase_q), 32'd0);
        last = -1; nticks = 0; nov = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (dut.tick_s === 1'b1) begin
                nticks++;
                if (last >= 0) check("tick_spacing", 32'(i - last), 32'd25);
                last = i;
            end
            if (out_valid !== 1'b0) nov++;
        end
        check("tick_count", 32'(nticks), 32'd16);
        check("prime_no_out_valid", 32'(nov), 32'd0);

        // upward interpolation at phase 2045
        do_reset();
        wait_tick_in(16);
        pulse(16'sd0);
        step(9);
        pulse(16'sd1000);
        step(7);
        check("up_early_strobe", 32'(out_valid), 32'd0);
        step(1);
        check("up_valid", 32'(out_valid), 32'd1);
        check("up_data", 32'(data_out), 32'd499);

        // downward, negative slope
        do_reset();
        wait_tick_in(16);
        pulse(16'sd1000);
        step(9);
        pulse(-16'sd1000);
        step(8);
        check("down_valid", 32'(out_valid), 32'd1);
        check("down_data", 32'(data_out), 32'd1);
        check("down_no_underrun", 32'(underrun), 32'd0);

        // stalled input: phase saturates, underrun sticks
        do_reset();
        wait_tick_in(24);
        pulse(16'sd0);
        pulse(16'sd1000);
        step(20);
        check("ur_flag", 32'(underrun), 32'd1);
        check("ur_phase_pinned", 32'(dut.phase_q), 32'd4095);
        step(5);
        check("ur_valid", 32'(out_valid), 32'd1);
        check("ur_data", 32'(data_out), 32'd1000);
        pulse(16'sd500);
        step(2);
        check("ur_sticky", 32'(underrun), 32'd1);

        // input sample colliding with the tick
        do_reset();
        wait_tick_in(21);
        pulse(16'sd0);
        step(9);
        pulse(16'sd1000);
        step(10);
        pulse(16'sd2000);
        step(2);
        check("coll_valid", 32'(out_valid), 32'd1);
        check("coll_data", 32'(data_out), 32'd999);
        check("coll_input_taken", 32'(dut.s_curr_q), 32'd2000);

        // reset one cycle after the tick kills the in-flight result
        do_reset();
        wait_tick_in(16);
        pulse(16'sd0);
        step(9);
        pulse(16'sd1000);
        step(6);
        reset_n = 1'b0;
        step(2);
        check("rstmid_no_valid", 32'(out_valid), 32'd0);
        check("rstmid_data", 32'(data_out), 32'd0);
        check("rstmid_underrun", 32'(underrun), 32'd0);
        reset_n = 1'b1;
        pulse(16'sd500);
        nov = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) nov++;
        end
        check("rstmid_one_sample_silent", 32'(nov), 32'd0);
        pulse(16'sd700);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("rstmid_resumes", 32'(seen), 32'd1);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
